// File: rtl/hex_display_scan.v.sv
// hex_display_scan: time-multiplexed driver for NUM_DIGITS common-anode 7-segment hex digits.
// Optional decimal-point output is enabled by defining HEX_DISPLAY_SCAN_DP_EN.
module hex_display_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_load,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   input  logic [NUM_DIGITS-1:0]   i_blank_mask,
   input  logic [NUM_DIGITS-1:0]   i_blink_mask,
   input  logic                    i_lz_blank,
`ifdef HEX_DISPLAY_SCAN_DP_EN
   input  logic [NUM_DIGITS-1:0]   i_dp_mask,
   output logic                    o_dp,
`endif
   output logic [6:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_frame
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW    = $clog2(SCAN_DIV);
   localparam int BW    = $clog2(BLINK_FRAMES + 1);

   logic [NUM_DIGITS-1:0][3:0] r_data;
   logic [NUM_DIGITS-1:0]      r_blank;
   logic [NUM_DIGITS-1:0]      r_blink;
   logic                       r_lz;
   logic [PW-1:0]              r_presc;
   logic [IDX_W-1:0]           r_idx;
   logic [BW-1:0]              r_bcnt;
   logic                       r_phase;   // 1 = blinking digits visible

   logic [NUM_DIGITS-1:0]      w_upz;
   logic [3:0]                 w_nib;
   logic                       w_dark;
   logic                       w_step;
   logic                       w_last;
   logic [NUM_DIGITS-1:0]      w_an;
   logic [6:0]                 w_seg;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'h0: f_decode = 7'h40;
         4'h1: f_decode = 7'h79;
         4'h2: f_decode = 7'h24;
         4'h3: f_decode = 7'h30;
         4'h4: f_decode = 7'h19;
         4'h5: f_decode = 7'h12;
         4'h6: f_decode = 7'h02;
         4'h7: f_decode = 7'h78;
         4'h8: f_decode = 7'h00;
         4'h9: f_decode = 7'h10;
         4'hA: f_decode = 7'h08;
         4'hB: f_decode = 7'h03;
         4'hC: f_decode = 7'h27;
         4'hD: f_decode = 7'h21;
         4'hE: f_decode = 7'h06;
         default: f_decode = 7'h0E;
      endcase
   endfunction

   // w_upz[i]: nibbles i..NUM_DIGITS-1 are all zero (blanked digits still count)
   always_comb begin
      w_upz = '0;
      w_upz[NUM_DIGITS-1] = (r_data[NUM_DIGITS-1] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         w_upz[i] = (r_data[i] == 4'h0) && w_upz[i+1];
   end

   always_comb begin
      w_step = (r_presc == PW'(SCAN_DIV - 1));
      w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
      w_nib  = r_data[r_idx];
      w_dark = r_blank[r_idx] | (r_blink[r_idx] & ~r_phase) |
               (r_lz & (r_idx != '0) & w_upz[r_idx]);
      w_an   = '1;
      w_seg  = 7'h7F;
      if (!w_dark) begin
         w_an[r_idx] = 1'b0;
         w_seg       = f_decode(w_nib);
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_data  <= '0;
         r_blank <= '0;
         r_blink <= '0;
         r_lz    <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_blank <= i_blank_mask;
         r_blink <= i_blink_mask;
         r_lz    <= i_lz_blank;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_presc <= '0;
         r_idx   <= '0;
         o_frame <= 1'b0;
      end else begin
         o_frame <= w_step & w_last;
         if (w_step) begin
            r_presc <= '0;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Blink counter advances on the registered frame pulse
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_bcnt  <= '0;
         r_phase <= 1'b1;
      end else if (o_frame) begin
         if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_bcnt  <= r_bcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_seg <= 7'h7F;
         o_an  <= '1;
      end else begin
         o_seg <= w_seg;
         o_an  <= w_an;
      end
   end

`ifdef HEX_DISPLAY_SCAN_DP_EN
   logic [NUM_DIGITS-1:0] r_dp_mask;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_dp_mask <= '0;
         o_dp      <= 1'b1;
      end else begin
         if (i_load) r_dp_mask <= i_dp_mask;
         o_dp <= w_dark | ~r_dp_mask[r_idx];
      end
   end
`endif

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed self-checking bench for hex_display_scan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
// Expected outputs come from hand-typed decode constants and cycle arithmetic.
module tb_hex_display_scan;

   logic        clk = 1'b0;
   logic        resetn;
   logic        load;
   logic [15:0] data;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic        lz_blank;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame;
`ifdef HEX_DISPLAY_SCAN_DP_EN
   logic [3:0]  dp_mask;
   logic        dp;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // bench copy of the loaded registers
   logic [15:0] m_data;
   logic [3:0]  m_blank, m_blink, m_dp;
   logic        m_lz;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

   hex_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_load       (load),
      .i_data       (data),
      .i_blank_mask (blank_mask),
      .i_blink_mask (blink_mask),
      .i_lz_blank   (lz_blank),
`ifdef HEX_DISPLAY_SCAN_DP_EN
      .i_dp_mask    (dp_mask),
      .o_dp         (dp),
`endif
      .o_seg        (seg),
      .o_an         (an),
      .o_frame      (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // blink phase as seen by the output registers at edge n after reset release
   function automatic bit phase_on(input int n);
      if (n < 2) return 1'b1;
      return ((n - 2) / 32) % 2 == 0;
   endfunction

   task automatic check_outputs(input string tag);
      int d;
      bit dark;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      d    = ((cyc - 1) / 4) % 4;
      dark = m_blank[d] || (m_blink[d] && !phase_on(cyc)) ||
             (m_lz && d != 0 && (m_data >> (4 * d)) == 16'h0);
      e_seg = dark ? 7'h7F : dec[m_data[4*d +: 4]];
      e_an  = dark ? 4'hF : ~(4'b0001 << d);
      chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
      chk({tag, ".an"}, {4'h0, an}, {4'h0, e_an});
      chk({tag, ".frame"}, {7'h0, frame}, {7'h0, (cyc % 16) == 0});
`ifdef HEX_DISPLAY_SCAN_DP_EN
      chk({tag, ".dp"}, {7'h0, dp}, {7'h0, dark || !m_dp[d]});
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_scan(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         check_outputs(tag);
      end
   endtask

   // edge after the load strobe still shows the old registers
   task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                          input logic lz, input logic [3:0] dpm);
      data = d; blank_mask = bl; blink_mask = bk; lz_blank = lz;
`ifdef HEX_DISPLAY_SCAN_DP_EN
      dp_mask = dpm;
`endif
      load = 1'b1;
      tick();
      load = 1'b0;
      data = 16'hFFFF; blank_mask = 4'hF; blink_mask = 4'hF; lz_blank = 1'b1;
`ifdef HEX_DISPLAY_SCAN_DP_EN
      dp_mask = 4'h0;
`endif
      check_outputs("load_edge");
      m_data = d; m_blank = bl; m_blink = bk; m_lz = lz; m_dp = dpm;
   endtask

   initial begin
      resetn = 1'b0; load = 1'b0; data = '0; blank_mask = '0; blink_mask = '0; lz_blank = 1'b0;
`ifdef HEX_DISPLAY_SCAN_DP_EN
      dp_mask = '0;
`endif
      m_data = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0; m_dp = '0;

      repeat (3) @(negedge clk);
      chk("rst.seg", {1'b0, seg}, 8'h7F);
      chk("rst.an", {4'h0, an}, 8'h0F);
      chk("rst.frame", {7'h0, frame}, 8'h00);
`ifdef HEX_DISPLAY_SCAN_DP_EN
      chk("rst.dp", {7'h0, dp}, 8'h01);
`endif
      resetn = 1'b1;

      run_scan("idle", 16);
      do_load(16'hA3F1, 4'h0, 4'h0, 1'b0, 4'h0);
      run_scan("a3f1", 15);
      do_load(16'h0005, 4'h0, 4'h0, 1'b1, 4'h0);
      run_scan("lz5", 16);
      do_load(16'h0000, 4'h0, 4'h0, 1'b1, 4'h0);
      run_scan("lz0", 16);
      do_load(16'h0100, 4'b0100, 4'h0, 1'b1, 4'h0);
      run_scan("lzblank", 16);
      do_load(16'h8888, 4'h0, 4'b0010, 1'b0, 4'b0100);
      run_scan("blink", 64);
      do_load(16'h1234, 4'b1000, 4'h0, 1'b0, 4'b0100);
      run_scan("blank3", 2);

      // land in the middle of digit 2, then reset asynchronously
      while (((cyc - 1) / 4) % 4 != 2 || (cyc - 1) % 4 != 1) run_scan("to_d2", 1);
      chk("mid_d2.an", {4'h0, an}, 8'h0B);
      #1 resetn = 1'b0;
      #1;
      chk("async.seg", {1'b0, seg}, 8'h7F);
      chk("async.an", {4'h0, an}, 8'h0F);
      chk("async.frame", {7'h0, frame}, 8'h00);
      @(negedge clk);
      chk("held.an", {4'h0, an}, 8'h0F);
      resetn = 1'b1;
      cyc = 0;
      m_data = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0; m_dp = '0;
      run_scan("restart", 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment hex digits sharing one segment bus.
- Latches a packed nibble word on a load strobe and scans one digit per SCAN_DIV clocks.
- Supports per-digit blanking, per-digit blinking and leading-zero suppression.
- Sits between datapath/status registers and the board's multiplexed display pins; successor to the single-digit static decoder.

Parameters:
- NUM_DIGITS, 4, digits driven; legal 1..8.
- SCAN_DIV, 50000, clocks each digit is enabled; legal >= 2.
- BLINK_FRAMES, 32, full scan frames per blink half-period; legal >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures data, blank_mask, blink_mask, lz_blank.
- data  in  4*NUM_DIGITS  packed nibbles; digit i = data[4i+3:4i]; digit 0 least significant.
- blank_mask  in  NUM_DIGITS  1 = digit i always dark.
- blink_mask  in  NUM_DIGITS  1 = digit i dark during blink-off phase.
- lz_blank  in  1  1 = suppress leading zeros.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, at most one low.
- frame  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn. All state and outputs are registered.
- Reset values:
  - data_reg, mask registers and lz_reg = 0.
  - prescaler = 0, digit index = 0.
  - blink phase = on (visible), blink frame counter = 0.
  - seg = 7'h7F, an = all ones, frame = 0.
- Reset mid-scan aborts immediately to the reset values above.
- Load:
  - When load=1 at a clk edge, all inputs are captured into data_reg, mask registers and lz_reg.
  - Outputs reflect the new value one clock later, for whichever digit is then active.
  - Load never disturbs prescaler, digit index or blink state.
  - While load=0, input changes are ignored.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and then wraps.
  - On the edge where prescaler == SCAN_DIV-1, the index increments, wrapping NUM_DIGITS-1 -> 0.
  - frame is asserted for the single cycle following that wrap.
  - Each digit is enabled for exactly SCAN_DIV consecutive cycles; a frame lasts NUM_DIGITS*SCAN_DIV cycles.
  - NUM_DIGITS=1: index stays 0 and frame pulses every SCAN_DIV cycles.
- Outputs (registered; one cycle latency from index/data_reg):
  - an = all ones except bit[index] = 0, when the digit is visible.
  - seg = decode(nibble[index]) when visible.
  - A dark digit drives seg = 7'h7F and an = all ones.
- Decode (gfedcba, active-low):
  - 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78
  - 8 00, 9 10, A 08, b 03, c 27, d 21, E 06, F 0E (hex).
- A digit is dark when any of these holds:
  - its blank_mask bit = 1;
  - its blink_mask bit = 1 and blink phase = off;
  - lz_reg = 1, index != 0, and nibbles index..NUM_DIGITS-1 are all zero.
- Digit 0 is never leading-zero blanked.
- Digits with blank_mask=1 still count as values for leading-zero evaluation; blanking is purely visual.
- Blink:
  - The frame counter increments on each frame pulse.
  - On reaching BLINK_FRAMES, the counter clears to 0 and the phase toggles.
- Load coinciding with a scan step: both take effect; the new digit shows the new data.

Optional Feature:
- Macro HEX_DISPLAY_SCAN_DP_EN.
- When defined, adds:
  - input dp_mask[NUM_DIGITS-1:0], captured on load;
  - output dp (active-low), registered, reset 1.
- dp = ~dp_mask[index] while the digit is visible; dp = 1 when the digit is dark.
- Blink applies to dp with its digit. Leading-zero blanking also darkens dp.
- When not defined, neither port exists and the behaviour is otherwise identical.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 unless stated):
- Reset, then release with no load -> seg=7F and an=F at reset. Digit 0 shows "0": seg=40, an=E for 4 cycles, then an=D/B/7 each for 4 cycles. frame pulses once per 16 cycles.
- load data=16'hA3F1 -> successive digits show seg=79 (1), 0E (F), 30 (3), 08 (A). Output changes 1 cycle after load; scan phase is unaffected.
- load data=16'h0005, lz_blank=1 -> digit 0 seg=12/an=E. Digits 1-3 give seg=7F/an=F. With data=16'h0000, only digit 0 is lit (seg=40).
- load blink_mask=4'b0010, data=16'h8888 -> digit 1 is lit (seg=00) for frames 0-1, dark for frames 2-3, then lit again. The other digits stay lit throughout.
- blank_mask=4'b1000 with data=16'h1234 -> digit 3 is dark. Assert resetn=0 mid-digit-2, asynchronously -> seg=7F and an=F immediately. After release, scan restarts at digit 0 showing "0".
- With HEX_DISPLAY_SCAN_DP_EN defined, load dp_mask=4'b0100 -> dp=0 only while an=B, otherwise dp=1.
